// File: rtl/tracker_pkg.sv
// Shared encodings for the line tracker: motor mode codes, FSM states and sensor decode.
package tracker_pkg;

   localparam int TICK_DIV_DEF   = 100_000;
   localparam int DEB_CNT_DEF    = 4;
   localparam int LOST_TICKS_DEF = 500;
   localparam int OBST_CM_DEF    = 20;
   localparam int OBST_HYST_DEF  = 5;

   typedef enum logic [1:0] {
      MODE_STOP  = 2'b00,
      MODE_GO    = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_LEFT  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_SEARCH = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      DEC_GO    = 3'd0,
      DEC_LEFT  = 3'd1,
      DEC_RIGHT = 3'd2,
      DEC_LOST  = 3'd3,
      DEC_AMBIG = 3'd4
   } dec_t;

   // Vector order is {left, mid, right}; 1 means the sensor sees the black line.
   function automatic dec_t decode_vec(input logic [2:0] v);
      case (v)
         3'b010, 3'b111: return DEC_GO;
         3'b110, 3'b100: return DEC_LEFT;
         3'b011, 3'b001: return DEC_RIGHT;
         3'b000:         return DEC_LOST;
         default:        return DEC_AMBIG;
      endcase
   endfunction

   function automatic mode_t dec_to_mode(input dec_t d);
      case (d)
         DEC_GO:    return MODE_GO;
         DEC_LEFT:  return MODE_LEFT;
         DEC_RIGHT: return MODE_RIGHT;
         default:   return MODE_STOP;
      endcase
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Sample tick generator and run-length debounce filter for the 3 IR sensors.
module sensor_debounce
   import tracker_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int DEB_CNT  = DEB_CNT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   input  logic [2:0] sensor,
   output logic       tick,
   output logic [2:0] accepted
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(DEB_CNT + 1);

   logic [TW-1:0] tick_cnt;
   logic [2:0]    sync_a, sync_b, prev;
   logic [CW-1:0] run_cnt, run_nxt;

   assign tick = !hold && (tick_cnt == TW'(TICK_DIV - 1));

   always_comb begin
      run_nxt = CW'(1);
      if (sync_b == prev)
         run_nxt = (run_cnt == CW'(DEB_CNT)) ? run_cnt : run_cnt + CW'(1);
   end

   // Sensors are asynchronous to clk, so they pass a 2-flop synchronizer first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a   <= 3'b000;
         sync_b   <= 3'b000;
         tick_cnt <= '0;
         prev     <= 3'b000;
         run_cnt  <= '0;
         accepted <= 3'b000;
      end else begin
         sync_a <= sensor;
         sync_b <= sync_a;
         if (!hold) begin
            if (tick) begin
               tick_cnt <= '0;
               prev     <= sync_b;
               run_cnt  <= run_nxt;
               if (run_nxt == CW'(DEB_CNT))
                  accepted <= sync_b;
            end else begin
               tick_cnt <= tick_cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/line_tracker_fsm.sv
// Line-follower decision FSM driving the motor mode bus.
// Define OBSTACLE_STOP_EN to add the ultrasonic obstacle interlock (dist_cm/dist_valid).
module line_tracker_fsm
   import tracker_pkg::*;
#(
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int DEB_CNT    = DEB_CNT_DEF,
   parameter int LOST_TICKS = LOST_TICKS_DEF,
   parameter int OBST_CM    = OBST_CM_DEF,
   parameter int OBST_HYST  = OBST_HYST_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] sensor,
   output logic [1:0] mode,
   output logic       lost,
`ifdef OBSTACLE_STOP_EN
   input  logic [8:0] dist_cm,
   input  logic       dist_valid,
`endif
   output state_t     state_dbg
);

   localparam int LW = $clog2(LOST_TICKS + 1);

   state_t        state;
   mode_t         mode_q, cmd_q, last_turn, dec_mode;
   dec_t          dec;
   logic [LW-1:0] lost_cnt;
   logic          tick, blocked;
   logic [2:0]    accepted;

   sensor_debounce #(.TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT)) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .hold     (blocked),
      .sensor   (sensor),
      .tick     (tick),
      .accepted (accepted)
   );

   assign dec       = decode_vec(accepted);
   assign dec_mode  = dec_to_mode(dec);
   assign mode      = mode_q;
   assign lost      = (state == ST_SEARCH) || (state == ST_HALT);
   assign state_dbg = state;

`ifdef OBSTACLE_STOP_EN
   // dist_valid is a one-cycle strobe with no back-pressure: each sample is used in
   // the cycle it is presented and never stalled. Hysteresis avoids chatter at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blocked <= 1'b0;
      else if (dist_valid) begin
         if (dist_cm < 9'(OBST_CM))
            blocked <= 1'b1;
         else if (dist_cm >= 9'(OBST_CM + OBST_HYST))
            blocked <= 1'b0;
      end
   end
`else
   assign blocked = 1'b0;
`endif

   // cmd_q holds the FSM's own command so mode can resume it after an obstacle clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_STOP;
         cmd_q     <= MODE_STOP;
         last_turn <= MODE_GO;
         lost_cnt  <= '0;
      end else if (blocked) begin
         mode_q <= MODE_STOP;
      end else if (!en) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_STOP;
         cmd_q    <= MODE_STOP;
         lost_cnt <= '0;
      end else begin
         mode_q <= cmd_q;
         case (state)
            ST_IDLE, ST_TRACK: begin
               if (dec == DEC_LOST) begin
                  if (state == ST_TRACK) begin
                     state    <= ST_SEARCH;
                     lost_cnt <= '0;
                     mode_q   <= last_turn;
                     cmd_q    <= last_turn;
                  end
               end else begin
                  state <= ST_TRACK;
                  if (dec != DEC_AMBIG) begin
                     mode_q    <= dec_mode;
                     cmd_q     <= dec_mode;
                     last_turn <= dec_mode;
                  end
               end
            end
            ST_SEARCH: begin
               if (dec != DEC_LOST) begin
                  state    <= ST_TRACK;
                  lost_cnt <= '0;
                  if (dec != DEC_AMBIG) begin
                     mode_q    <= dec_mode;
                     cmd_q     <= dec_mode;
                     last_turn <= dec_mode;
                  end
               end else if (tick) begin
                  lost_cnt <= lost_cnt + LW'(1);
                  if (lost_cnt == LW'(LOST_TICKS - 1)) begin
                     state  <= ST_HALT;
                     mode_q <= MODE_STOP;
                     cmd_q  <= MODE_STOP;
                  end
               end
            end
            default: begin
               mode_q <= MODE_STOP;
               cmd_q  <= MODE_STOP;
            end
         endcase
      end
   end

endmodule
